// File: rtl/atm_dec_pkg.sv
// Shared types and constants for the ATM control-path one-hot strobe decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package atm_dec_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int MODE_LEVEL    = 0;
  localparam int MODE_PULSE    = 1;
  localparam int PULSE_LEN_MAX = 255;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decode with an in-range flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; out-of-range codes decode to all-zero with in_range low.
module onehot_dec
  import atm_dec_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int NUM_OUT = 16
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot,
  output logic               in_range
);

  // Compare one bit wider than SEL so NUM_OUT = 2**SEL_W still fits.
  localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(NUM_OUT);

  logic [SEL_W:0] sel_ext;
  assign sel_ext = {1'b0, sel};

  // Decode each line independently; out-of-range codes match no line.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      onehot[i] = (sel_ext == (SEL_W+1)'(i));
    end
    in_range = (sel_ext < LIMIT);
  end

endmodule

// File: rtl/onehot_strobe_decoder.sv
// Registered select-to-one-hot driver with level (hold) or pulse (strobe) output.
// Latency: command accepted at an edge shows on Y/ERR right after that edge.
// Backpressure: READY low while a strobe runs; LOAD is ignored (not queued) then.
module onehot_strobe_decoder
  import atm_dec_pkg::*;
#(
  parameter int SEL_W     = 4,
  parameter int NUM_OUT   = 16,
  parameter int MODE      = 0,
  parameter int PULSE_LEN = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               CLR,
  input  logic               LOAD,
  input  logic [SEL_W-1:0]   SEL,
  output logic               READY,
  output logic [NUM_OUT-1:0] Y,
  output logic               BUSY,
  output logic               ERR
);

  localparam int CNT_RAW = $clog2(PULSE_LEN + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  // Elaboration-time parameter range checks.
  if (SEL_W < 1 || SEL_W > 8) begin : g_bad_sel_w
    $error("onehot_strobe_decoder: SEL_W must be 1..8");
  end
  if (NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_bad_num_out
    $error("onehot_strobe_decoder: NUM_OUT must be 2..2**SEL_W");
  end
  if (MODE != MODE_LEVEL && MODE != MODE_PULSE) begin : g_bad_mode
    $error("onehot_strobe_decoder: MODE must be 0 or 1");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > PULSE_LEN_MAX) begin : g_bad_pulse_len
    $error("onehot_strobe_decoder: PULSE_LEN must be 1..255");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_OUT-1:0] dec_y;
  logic               in_range;
  logic               accept;

  onehot_dec #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_dec (
    .sel      (SEL),
    .onehot   (dec_y),
    .in_range (in_range)
  );

  // READY is the only output decoded straight from state.
  assign READY  = (state == IDLE);
  assign accept = LOAD & READY & ~CLR;

  // Command capture, strobe countdown and clear/reset handling.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      state <= IDLE;
      cnt   <= '0;
      Y     <= '0;
      BUSY  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      ERR <= 1'b0;
      if (accept) begin
        if (!in_range) begin
          // Bad code: flag it, drop any held line, leave the FSM alone.
          Y   <= '0;
          ERR <= 1'b1;
        end else if (!EN) begin
          Y <= '0;
        end else begin
          Y <= dec_y;
          if (MODE == MODE_PULSE) begin
            state <= ACTIVE;
            BUSY  <= 1'b1;
            cnt   <= CNT_W'(PULSE_LEN - 1);
          end
        end
      end else if (state == ACTIVE) begin
        // Counter holds the number of further cycles Y stays high.
        if (cnt == '0) begin
          Y     <= '0;
          state <= IDLE;
          BUSY  <= 1'b0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Bench for onehot_strobe_decoder: five configurations share one stimulus stream.
// Each cycle every instance is compared with a cycle-level behavioural model.
// Table vectors, hand-written strobe sequences and random traffic drive the inputs.
module tb_onehot_strobe_decoder;

  // Instance configurations: 0 level/16, 1 pulse L=3, 2 level/10, 3 pulse L=4, 4 pulse L=1 SEL_W=3/8
  localparam int NI = 5;
  localparam int P_NUM_OUT [NI] = '{16, 16, 10, 16, 8};
  localparam int P_MODE    [NI] = '{0, 1, 0, 1, 1};
  localparam int P_PLEN    [NI] = '{1, 3, 1, 4, 1};
  localparam int P_SEL_W   [NI] = '{4, 4, 4, 4, 3};

  logic       clk;
  logic       rst, en, clr, load;
  logic [3:0] sel;

  logic [15:0] y0, y1, y3;
  logic [9:0]  y2;
  logic [7:0]  y4;
  logic        rdy [NI];
  logic        busy [NI];
  logic        err [NI];
  logic [15:0] dut_y [NI];

  assign dut_y[0] = y0;
  assign dut_y[1] = y1;
  assign dut_y[2] = {6'b0, y2};
  assign dut_y[3] = y3;
  assign dut_y[4] = {8'b0, y4};

  onehot_strobe_decoder #(.SEL_W(4), .NUM_OUT(16), .MODE(0), .PULSE_LEN(1)) u_lvl16 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LOAD(load), .SEL(sel),
    .READY(rdy[0]), .Y(y0), .BUSY(busy[0]), .ERR(err[0]));
  onehot_strobe_decoder #(.SEL_W(4), .NUM_OUT(16), .MODE(1), .PULSE_LEN(3)) u_pls3 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LOAD(load), .SEL(sel),
    .READY(rdy[1]), .Y(y1), .BUSY(busy[1]), .ERR(err[1]));
  onehot_strobe_decoder #(.SEL_W(4), .NUM_OUT(10), .MODE(0), .PULSE_LEN(1)) u_lvl10 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LOAD(load), .SEL(sel),
    .READY(rdy[2]), .Y(y2), .BUSY(busy[2]), .ERR(err[2]));
  onehot_strobe_decoder #(.SEL_W(4), .NUM_OUT(16), .MODE(1), .PULSE_LEN(4)) u_pls4 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LOAD(load), .SEL(sel),
    .READY(rdy[3]), .Y(y3), .BUSY(busy[3]), .ERR(err[3]));
  onehot_strobe_decoder #(.SEL_W(3), .NUM_OUT(8), .MODE(1), .PULSE_LEN(1)) u_pls1 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LOAD(load), .SEL(sel[2:0]),
    .READY(rdy[4]), .Y(y4), .BUSY(busy[4]), .ERR(err[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vec_cnt = 0;
  int miscompares = 0;

  // Model state: index of the lit line (-1 = none), strobe cycles still to show, error flag.
  int m_y   [NI];
  int m_rem [NI];
  bit m_err [NI];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit c, input bit l, input bit e, input logic [3:0] s);
    for (int i = 0; i < NI; i++) begin
      int sv;
      bit ready_now;
      sv = int'(s) % (1 << P_SEL_W[i]);
      ready_now = (P_MODE[i] == 0) || (m_rem[i] == 0);
      if (r || c) begin
        m_y[i] = -1; m_rem[i] = 0; m_err[i] = 0;
      end else begin
        m_err[i] = 0;
        if (P_MODE[i] == 1 && m_rem[i] > 0) begin
          m_rem[i]--;
          if (m_rem[i] == 0) m_y[i] = -1;
        end
        if (l && ready_now) begin
          if (sv >= P_NUM_OUT[i]) begin
            m_y[i] = -1; m_err[i] = 1;
          end else if (!e) begin
            m_y[i] = -1;
          end else begin
            m_y[i] = sv;
            if (P_MODE[i] == 1) m_rem[i] = P_PLEN[i];
          end
        end
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < NI; i++) begin
      logic [15:0] ey;
      ey = (m_y[i] < 0) ? 16'h0 : (16'h1 << m_y[i]);
      check("model_y", i, {16'h0, dut_y[i]}, {16'h0, ey});
      check("model_ready", i, {31'h0, rdy[i]}, {31'h0, (P_MODE[i] == 0) || (m_rem[i] == 0)});
      check("model_busy", i, {31'h0, busy[i]}, {31'h0, m_rem[i] > 0});
      check("model_err", i, {31'h0, err[i]}, {31'h0, m_err[i]});
      check("onehot", i, {31'h0, $countones(dut_y[i]) <= 1}, 32'h1);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare on the falling edge.
  task automatic step(input bit r, input bit c, input bit l, input bit e, input logic [3:0] s);
    rst = r; clr = c; load = l; en = e; sel = s;
    @(posedge clk);
    model_update(r, c, l, e, s);
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    bit          rst, clr, load, en;
    logic [3:0]  sel;
    logic [15:0] ya;    // level, NUM_OUT = 16
    logic [15:0] yc;    // level, NUM_OUT = 10
    bit          errc;
  } vec_t;

  vec_t tbl [14];

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_y[i] = -1; m_rem[i] = 0; m_err[i] = 0;
    end
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; sel = 4'd0;

    //           rst clr ld en sel     ya        yc        errc
    tbl[0]  = '{1, 0, 0, 0, 4'd0,  16'h0000, 16'h0000, 0};
    tbl[1]  = '{0, 0, 1, 1, 4'd5,  16'h0020, 16'h0020, 0};
    tbl[2]  = '{0, 0, 0, 1, 4'd5,  16'h0020, 16'h0020, 0};
    tbl[3]  = '{0, 0, 1, 1, 4'd15, 16'h8000, 16'h0000, 1};
    tbl[4]  = '{0, 0, 0, 1, 4'd0,  16'h8000, 16'h0000, 0};
    tbl[5]  = '{0, 0, 1, 1, 4'd12, 16'h1000, 16'h0000, 1};
    tbl[6]  = '{0, 0, 1, 1, 4'd9,  16'h0200, 16'h0200, 0};
    tbl[7]  = '{0, 0, 1, 0, 4'd3,  16'h0000, 16'h0000, 0};
    tbl[8]  = '{0, 0, 1, 1, 4'd4,  16'h0010, 16'h0010, 0};
    tbl[9]  = '{0, 1, 1, 1, 4'd1,  16'h0000, 16'h0000, 0};
    tbl[10] = '{0, 0, 0, 1, 4'd1,  16'h0000, 16'h0000, 0};
    tbl[11] = '{0, 0, 1, 1, 4'd0,  16'h0001, 16'h0001, 0};
    tbl[12] = '{0, 0, 1, 1, 4'd10, 16'h0400, 16'h0000, 1};
    tbl[13] = '{0, 1, 1, 1, 4'd10, 16'h0000, 16'h0000, 0};

    // Table-driven level-mode vectors.
    for (int k = 0; k < 14; k++) begin
      step(tbl[k].rst, tbl[k].clr, tbl[k].load, tbl[k].en, tbl[k].sel);
      check("tbl_y_lvl16", k, {16'h0, dut_y[0]}, {16'h0, tbl[k].ya});
      check("tbl_y_lvl10", k, {16'h0, dut_y[2]}, {16'h0, tbl[k].yc});
      check("tbl_err_lvl10", k, {31'h0, err[2]}, {31'h0, tbl[k].errc});
      check("tbl_ready_lvl16", k, {31'h0, rdy[0]}, 32'h1);
    end

    // Pulse L=3: strobe of exactly 3 cycles, mid-strobe LOAD ignored.
    step(1, 0, 0, 0, 4'd0);
    step(0, 0, 1, 1, 4'd2);
    for (int c = 0; c < 3; c++) begin
      check("p3_y", c, {16'h0, dut_y[1]}, 32'h0004);
      check("p3_busy", c, {31'h0, busy[1]}, 32'h1);
      check("p3_ready", c, {31'h0, rdy[1]}, 32'h0);
      if (c < 2) step(0, 0, 1, 1, 4'd7);
    end
    step(0, 0, 1, 1, 4'd7);
    check("p3_fall_y", 0, {16'h0, dut_y[1]}, 32'h0);
    check("p3_fall_ready", 0, {31'h0, rdy[1]}, 32'h1);
    step(0, 0, 1, 1, 4'd7);
    check("p3_next_y", 0, {16'h0, dut_y[1]}, 32'h0080);

    // Pulse L=4: reset in the second strobe cycle, then a full fresh strobe.
    step(1, 0, 0, 0, 4'd0);
    step(0, 0, 1, 1, 4'd1);
    step(0, 0, 0, 1, 4'd0);
    check("p4_pre_rst_y", 0, {16'h0, dut_y[3]}, 32'h0002);
    step(1, 0, 0, 1, 4'd0);
    check("p4_rst_y", 0, {16'h0, dut_y[3]}, 32'h0);
    check("p4_rst_busy", 0, {31'h0, busy[3]}, 32'h0);
    check("p4_rst_ready", 0, {31'h0, rdy[3]}, 32'h1);
    check("p4_rst_err", 0, {31'h0, err[3]}, 32'h0);
    step(0, 0, 1, 1, 4'd0);
    begin
      int hi;
      hi = 0;
      for (int c = 0; c < 10; c++) begin
        if (dut_y[3] == 16'h0001) hi++;
        step(0, 0, 0, 1, 4'd0);
      end
      check("p4_strobe_len", 0, hi, 32'd4);
    end

    // SEL_W=3, NUM_OUT=8, L=1: LOAD SEL=7 held gives strobes every 2 cycles.
    step(1, 0, 0, 0, 4'd0);
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 1, 1, 4'd7);
      check("p1_y", c, {16'h0, dut_y[4]}, (c % 2 == 0) ? 32'h80 : 32'h0);
      check("p1_err", c, {31'h0, err[4]}, 32'h0);
    end

    // Random traffic against the model.
    step(1, 0, 0, 0, 4'd0);
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
